// File: rtl/arm_pkg.sv
// Shared core definitions: register index width and the hazard shadow-slot payload.
package arm_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r;
    logic [REG_ADDR_W-1:0] dest;
  } slot_t;

  localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc unless hold is set, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!hold && inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush/freeze controller with EXE/MEM shadow slots and perf counters.
// Define HAZARD_FORWARDING_EN when the EX forwarding unit exists (only load-use stalls).
module hazard_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  Two_src,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic                  hazard,
  output logic                  flush,
  output logic                  freeze,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;

  logic m1_exe, m2_exe, m1_mem, m2_mem;
  logic dep;

  assign freeze = !mem_ready;
  assign flush  = branch_taken;

  // Source-vs-producer compares; WB needs none since the regfile writes first half-cycle.
  always_comb begin
    m1_exe = exe_q.valid && exe_q.wb_en && (exe_q.dest == src1);
    m2_exe = Two_src && exe_q.valid && exe_q.wb_en && (exe_q.dest == src2);
    m1_mem = mem_q.valid && mem_q.wb_en && (mem_q.dest == src1);
    m2_mem = Two_src && mem_q.valid && mem_q.wb_en && (mem_q.dest == src2);
`ifdef HAZARD_FORWARDING_EN
    dep = exe_q.mem_r && (m1_exe || m2_exe);
`else
    dep = m1_exe || m2_exe || m1_mem || m2_mem;
`endif
    hazard = id_valid && !branch_taken && !freeze && dep;
  end

  // Slot advance: frozen holds everything, otherwise EXE shifts to MEM and ID (or a bubble) enters EXE.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d = exe_q;
      if (flush || hazard || !id_valid) begin
        exe_d = BUBBLE;
      end else begin
        exe_d = '{valid: 1'b1, wb_en: id_wb_en, mem_r: id_mem_r_en, dest: id_dest};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
    end
  end

  // The load flag is only consumed by the forwarding build; MEM's copy only by bookkeeping.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{exe_q.mem_r, mem_q};

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard),
    .hold  (freeze),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .hold  (freeze),
    .count (flush_count)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
- Keeps a shadow copy of the destination and control bits of the instructions in EXE and MEM.
- Compares those against the ID-stage sources (src1, src2, Two_src) to generate `hazard`, which stalls IF/ID and inserts a bubble into ID/EXE.
- Also generates branch `flush`, a memory-wait `freeze` and saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 4, register index width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src1  in  REG_ADDR_W  ID first source register (Rn).
- src2  in  REG_ADDR_W  ID second source register (Rm, or Rd for store).
- Two_src  in  1  ID instruction reads src2.
- id_valid  in  1  ID holds a real instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_r_en  in  1  ID instruction is a load.
- id_dest  in  REG_ADDR_W  ID destination register.
- branch_taken  in  1  EXE resolved a taken branch (B) this cycle.
- mem_ready  in  1  data memory ready; 0 means MEM is waiting.
- hazard  out  1  stall PC and IF/ID; ID/EXE loads a bubble.
- flush  out  1  squash IF/ID and ID/EXE contents.
- freeze  out  1  hold every pipeline register.
- stall_count  out  CNT_W  number of cycles with hazard=1.
- flush_count  out  CNT_W  number of taken branches.

Behaviour:
- Shadow slots EXE and MEM, each holding {valid, wb_en, mem_r, dest}.
- On reset, both slots are invalid, both counters are 0, and the reset is asynchronous.
  - Hence `hazard`=0 out of reset; `flush` follows `branch_taken`; `freeze` follows `!mem_ready`.
- `freeze` = !mem_ready, combinational.
- Slot update rule, on each rising edge:
  - While freeze=1, slots and counters hold.
  - Otherwise MEM <= EXE.
  - EXE <= bubble (valid=0) if flush, hazard or !id_valid; else EXE <= {1, id_wb_en, id_mem_r_en, id_dest}.
- Match definitions:
  - match_X(s) = slot X valid & wb_en & dest==s.
  - m1 = match on src1.
  - m2 = Two_src & match on src2.
- `hazard` (combinational):
  - hazard = id_valid & !branch_taken & !freeze & (m1 | m2) over EXE and MEM slots.
- WB stage needs no check: the register file writes in the first half-cycle, so a WB/ID overlap reads the new value.
- `flush` = branch_taken, combinational.
  - It overrides `hazard`: hazard is 0 whenever flush is 1.
  - The EXE slot loads a bubble on that edge. The instruction already in EXE (the branch) advances to MEM normally.
- Counters:
  - stall_count increments on each non-frozen edge with hazard=1.
  - flush_count increments on each non-frozen edge with flush=1.
  - Both saturate at all-ones with no wrap.
- Stall latency:
  - A dependent instruction stalls in ID until the producer leaves MEM: 2 cycles when directly behind the producer, 1 cycle with one gap.
- Simultaneous events:
  - freeze dominates everything; nothing advances and hazard is 0.
  - flush dominates hazard.
- Reset asserted mid-stall clears the slots immediately, so hazard drops the same cycle.
- Register 15 (PC) is matched like any other index; no special case.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: the EX-stage forwarding unit is present.
  - hazard = id_valid & !branch_taken & !freeze & EXE.mem_r & (m1_EXE | m2_EXE).
  - Only load-use stalls remain, giving a 1-cycle stall.
  - MEM-slot matches never stall.
- Undefined: full interlock as specified in Behaviour.

Decomposition:
- Shared package `arm_pkg`:
  - REG_ADDR_W.
  - Slot struct / field widths {valid, wb_en, mem_r, dest}.
  - BUBBLE constant (all-zero slot).
- One sub-module, `sat_counter` (width CNT_W, inc, hold), instantiated twice for the two counters.
- The slot pipeline and compare logic stay inline.

Test Plan:
- Reset: assert rst mid-stream with a valid EXE slot matching src1 -> hazard=0 immediately; stall_count=0, flush_count=0.
- RAW on EXE: ADD R1 (wb_en, dest=1) then SUB reading src1=1 -> hazard=1 for 2 cycles; stall_count=2 (no forwarding). With HAZARD_FORWARDING_EN -> hazard=0.
- Load-use: LDR dest=3 then ADD with Two_src=1, src2=3 -> hazard=1 exactly 1 cycle with HAZARD_FORWARDING_EN, 2 cycles without.
- Two_src=0 with src2 matching EXE dest -> hazard=0.
- Branch with pending hazard: branch_taken=1 while ID matches EXE -> flush=1, hazard=0; EXE slot becomes bubble next cycle; flush_count=1.
- Freeze: mem_ready=0 for 3 cycles during a RAW stall -> freeze=1, hazard=0, slots and stall_count unchanged. After mem_ready=1 the stall resumes, and counter saturation at 0xFFFF holds its value.
